clock_display_scanner: RTL and testbench



---
 rtl/clock_display_pkg.sv | 22 ++
 rtl/clock_display_scanner_decode.sv | 46 ++++
 rtl/clock_display_scanner.sv | 144 ++++++++++++++
 tb/tb_clock_display_scanner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// Shared types and segment constants for the MM:SS seven-segment scanner.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package clock_display_pkg;

  typedef enum logic [1:0] {
    DIG_SEC_ONES = 2'd0,
    DIG_SEC_TENS = 2'd1,
    DIG_MIN_ONES = 2'd2,
    DIG_MIN_TENS = 2'd3
  } digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  localparam logic [5:0] FIELD_MAX = 6'd59;

endpackage

// File: rtl/clock_display_scanner_decode.sv
// Binary 0..59 field to two seven-segment patterns; out-of-range fields show dashes.
module bcd_seg7_decode
  import clock_display_pkg::*;
(
  input  logic [5:0] value,
  input  logic       blank_zero_tens,
  output logic [6:0] tens_seg,
  output logic [6:0] ones_seg
);

  logic [3:0] tens;
  logic [3:0] ones;

  // Compare chain instead of a divider; the subtraction result always fits in 4 bits.
  always_comb begin
    tens = '0;
    ones = value[3:0];
    if (value >= 6'd50) begin
      tens = 4'd5;
      ones = 4'(value - 6'd50);
    end else if (value >= 6'd40) begin
      tens = 4'd4;
      ones = 4'(value - 6'd40);
    end else if (value >= 6'd30) begin
      tens = 4'd3;
      ones = 4'(value - 6'd30);
    end else if (value >= 6'd20) begin
      tens = 4'd2;
      ones = 4'(value - 6'd20);
    end else if (value >= 6'd10) begin
      tens = 4'd1;
      ones = 4'(value - 6'd10);
    end
  end

  always_comb begin
    if (value > FIELD_MAX) begin
      tens_seg = SEG_DASH;
      ones_seg = SEG_DASH;
    end else begin
      ones_seg = SEG_DIGIT[ones];
      tens_seg = (blank_zero_tens && (tens == '0)) ? SEG_BLANK : SEG_DIGIT[tens];
    end
  end

endmodule

// File: rtl/clock_display_scanner.sv
// Four-digit multiplexed MM:SS driver with frame-synchronous display update
// and anode guard time at the start of each digit slot.
module clock_display_scanner
  import clock_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned GUARD          = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       time_valid,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic       blank_lead,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int unsigned    PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]  GUARD_END  = PW'(GUARD);
  localparam logic [6:0]     SEG_INV    = {7{SEG_ACTIVE_LOW}};
  localparam logic [3:0]     AN_INV     = {4{AN_ACTIVE_LOW}};

  logic [PW-1:0] presc;
  logic          presc_tc;
  logic          frame_end;
  digit_idx_t    idx;
  digit_idx_t    idx_nxt;

  logic [5:0] shadow_min, shadow_sec;
  logic [5:0] disp_min, disp_sec;
  logic [6:0] min_tens_seg, min_ones_seg, sec_tens_seg, sec_ones_seg;

  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [3:0] an_nxt;

  assign presc_tc  = (presc == PRESC_LAST);
  assign frame_end = presc_tc && (idx == DIG_MIN_TENS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else if (presc_tc) presc <= '0;
    else presc <= presc + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx <= DIG_SEC_ONES;
    else idx <= idx_nxt;
  end

  always_comb begin
    idx_nxt = idx;
    if (presc_tc) begin
      unique case (idx)
        DIG_SEC_ONES: idx_nxt = DIG_SEC_TENS;
        DIG_SEC_TENS: idx_nxt = DIG_MIN_ONES;
        DIG_MIN_ONES: idx_nxt = DIG_MIN_TENS;
        DIG_MIN_TENS: idx_nxt = DIG_SEC_ONES;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_min <= '0;
      shadow_sec <= '0;
    end else if (time_valid) begin
      shadow_min <= minutes;
      shadow_sec <= seconds;
    end
  end

  // Display takes the shadow as it was before this edge, so a coincident sample waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_min <= '0;
      disp_sec <= '0;
    end else if (frame_end) begin
      disp_min <= shadow_min;
      disp_sec <= shadow_sec;
    end
  end

  bcd_seg7_decode u_min_dec (
    .value           (disp_min),
    .blank_zero_tens (blank_lead),
    .tens_seg        (min_tens_seg),
    .ones_seg        (min_ones_seg)
  );

  bcd_seg7_decode u_sec_dec (
    .value           (disp_sec),
    .blank_zero_tens (1'b0),
    .tens_seg        (sec_tens_seg),
    .ones_seg        (sec_ones_seg)
  );

  always_comb begin
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b0;
    an_nxt  = '0;
    unique case (idx)
      DIG_SEC_ONES: begin
        seg_nxt = sec_ones_seg;
        an_nxt  = 4'b0001;
      end
      DIG_SEC_TENS: begin
        seg_nxt = sec_tens_seg;
        an_nxt  = 4'b0010;
      end
      DIG_MIN_ONES: begin
        seg_nxt = min_ones_seg;
        an_nxt  = 4'b0100;
        dp_nxt  = (disp_sec <= FIELD_MAX) && !disp_sec[0];
      end
      DIG_MIN_TENS: begin
        seg_nxt = min_tens_seg;
        an_nxt  = 4'b1000;
      end
    endcase
    if (presc < GUARD_END) an_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_INV;
      dp         <= SEG_ACTIVE_LOW;
      an         <= AN_INV;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nxt ^ SEG_INV;
      dp         <= dp_nxt ^ SEG_ACTIVE_LOW;
      an         <= an_nxt ^ AN_INV;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_clock_display_scanner.sv
// Scoreboard bench: the driver pushes one expected frame per display frame,
// the monitor pops it at each frame start and checks every cycle's pins.
module tb_clock_display_scanner;

  localparam int FRAME = 32;

  typedef struct packed {
    logic [3:0][6:0] seg;
    logic            dp;
  } frame_t;

  typedef struct {
    bit blank;
    int c1, m1, s1;
    int c2, m2, s2;
  } row_t;

  logic       clk;
  logic       rst_n;
  logic       time_valid;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic       blank_lead;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  frame_t exp_q[$];
  frame_t cur;
  int disp_m, disp_s, shad_m, shad_s;
  row_t rows[8];

  clock_display_scanner #(
    .SCAN_DIV       (8),
    .GUARD          (2),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .time_valid (time_valid),
    .seconds    (seconds),
    .minutes    (minutes),
    .blank_lead (blank_lead),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] digit_pat(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic frame_t make_frame(input int mm, input int ss, input bit blank);
    frame_t f;
    if (ss > 59) begin
      f.seg[0] = 7'b1000000;
      f.seg[1] = 7'b1000000;
    end else begin
      f.seg[0] = digit_pat(ss % 10);
      f.seg[1] = digit_pat(ss / 10);
    end
    if (mm > 59) begin
      f.seg[2] = 7'b1000000;
      f.seg[3] = 7'b1000000;
    end else begin
      f.seg[2] = digit_pat(mm % 10);
      f.seg[3] = (blank && (mm / 10 == 0)) ? 7'b0000000 : digit_pat(mm / 10);
    end
    f.dp = (ss <= 59) && (ss % 2 == 0);
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Cycle k after release reflects prescaler (k-1)%8 and digit ((k-1)/8)%4.
  always @(negedge clk) begin
    int k, d, p;
    logic [3:0] an_e;
    if (rst_n && cyc >= 1) begin
      k = cyc;
      p = (k - 1) % 8;
      d = ((k - 1) / 8) % 4;
      if ((k - 1) % FRAME == 0) begin
        check($sformatf("sb_avail@%0d", k), 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
      end
      an_e = (p < 2) ? 4'b0000 : (4'b0001 << d);
      check($sformatf("an@%0d", k), 32'(an), 32'(an_e));
      check($sformatf("seg@%0d", k), 32'(seg), 32'(cur.seg[d]));
      check($sformatf("dp@%0d", k), 32'(dp), 32'((d == 2) && cur.dp));
      check($sformatf("frame_done@%0d", k), 32'(frame_done), 32'(k % FRAME == 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input row_t r);
    bit fired;
    int vm, vs;
    exp_q.push_back(make_frame(disp_m, disp_s, r.blank));
    blank_lead = r.blank;
    for (int j = 1; j <= FRAME; j++) begin
      fired = 1'b0;
      if (j == r.c1) begin
        fired = 1'b1; vm = r.m1; vs = r.s1;
      end else if (j == r.c2) begin
        fired = 1'b1; vm = r.m2; vs = r.s2;
      end
      time_valid = fired;
      minutes = fired ? 6'(vm) : 6'($urandom_range(0, 63));
      seconds = fired ? 6'(vs) : 6'($urandom_range(0, 63));
      tick();
      if (j == FRAME) begin
        disp_m = shad_m;
        disp_s = shad_s;
      end
      if (fired) begin
        shad_m = vm;
        shad_s = vs;
      end
    end
    time_valid = 1'b0;
  endtask

  initial begin
    row_t idle;
    idle = '{blank: 1'b0, c1: 0, m1: 0, s1: 0, c2: 0, m2: 0, s2: 0};
    rows[0] = '{1'b0, 12, 12, 34, 0, 0, 0};
    rows[1] = '{1'b1, 12, 5, 7, 0, 0, 0};
    rows[2] = '{1'b1, 12, 60, 45, 0, 0, 0};
    rows[3] = '{1'b1, 12, 0, 59, 0, 0, 0};
    rows[4] = '{1'b1, 32, 23, 58, 0, 0, 0};
    rows[5] = idle;
    rows[6] = '{1'b0, 8, 44, 1, 20, 59, 60};
    rows[7] = idle;

    rst_n = 1'b0;
    time_valid = 1'b0;
    minutes = '0;
    seconds = '0;
    blank_lead = 1'b0;
    disp_m = 0; disp_s = 0; shad_m = 0; shad_s = 0;

    #22;
    check("rst_an", 32'(an), 32'd0);
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) run_frame(rows[r]);

    // Partial frame 8, then reset in the middle of the digit-2 slot.
    exp_q.push_back(make_frame(disp_m, disp_s, 1'b0));
    blank_lead = 1'b0;
    repeat (20) tick();
    check("an_before_reset", 32'(an), 32'(4'b0100));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'd0);
    check("async_rst_seg", 32'(seg), 32'd0);
    check("async_rst_dp", 32'(dp), 32'd0);
    check("async_rst_frame_done", 32'(frame_done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    disp_m = 0; disp_s = 0; shad_m = 0; shad_s = 0;
    rst_n = 1'b1;
    run_frame(idle);
    run_frame(idle);
    #6;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
